mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative, parametrised HI/LO arithmetic unit for the multicycle datapath.
- Executes MULT (shift-add) and DIV (restoring) over WIDTH cycles, signed or unsigned.
- Started by single-cycle MultCtrl/DivCtrl pulses from the control unit.
- Returns a one-cycle done pulse and registered hi/lo results. Flags divide-by-zero for the exception path.

Parameters:
WIDTH, 32, operand width; hi_out/lo_out each WIDTH bits; iteration count = WIDTH.
SIGNED_EN, 1, 1: honour is_signed input; 0: is_signed ignored, always unsigned.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
MultCtrl  input  1  start multiply, sampled only in IDLE
DivCtrl  input  1  start divide, sampled only in IDLE
is_signed  input  1  two's-complement mode for the started operation
a_in  input  WIDTH  multiplicand / dividend, captured at start
b_in  input  WIDTH  multiplier / divisor, captured at start
hi_out  output  WIDTH  mult: upper product half; div: remainder
lo_out  output  WIDTH  mult: lower product half; div: quotient
busy  output  1  high in every non-IDLE state
done  output  1  one-cycle pulse, results valid
DivZero  output  1  one-cycle pulse coincident with done when divisor was zero

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; hi_out=0, lo_out=0, busy=0, done=0, DivZero=0.
  - Internal counter and working registers are cleared.
  - Reset mid-operation aborts the operation; no done pulse is generated.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - MultCtrl=1 at a rising edge (E0): capture operands, latch op=MULT, go to RUN.
  - DivCtrl=1 at E0: latch op=DIV. If b_in==0, go directly to DONE with a divide-by-zero flag; otherwise go to RUN.
  - MultCtrl and DivCtrl both high: MULT wins.
- Operand capture at start:
  - Signed mode is active when SIGNED_EN=1 and is_signed=1.
  - Signed mode: operands converted to magnitudes; result sign and dividend sign are stored.
  - Unsigned mode: operands used as-is.
- RUN: exactly WIDTH cycles; counter counts WIDTH-1 down to 0.
  - MULT: one shift-add step per cycle on a 2*WIDTH accumulator.
  - DIV: one restoring step per cycle; partial remainder is WIDTH+1 bits; one quotient bit per cycle.
  - Exit to FIX when counter==0.
- FIX: one cycle.
  - MULT, signed, result negative: 2*WIDTH product negated.
  - DIV, signed: quotient negated if operand signs differ; remainder negated if dividend negative (remainder sign follows dividend).
  - hi_out/lo_out are loaded at the FIX->DONE edge.
- DONE: one cycle.
  - done=1.
  - DivZero=1 only for the zero-divisor path.
  - Returns to IDLE.
- Latency, counting cycle 1 as the cycle after E0:
  - Normal operation: done high in cycle WIDTH+2 (34 for WIDTH=32).
  - Divide-by-zero: done and DivZero high in cycle 1.
- Divide-by-zero: hi_out/lo_out keep their previous values.
- hi_out/lo_out change only at the FIX->DONE edge. They hold between operations and across ignored starts.
- Start pulses while busy=1 are ignored; there is no queueing.
- A start on the same edge on which DONE returns to IDLE is not sampled. It is sampled from the following cycle on.
- Signed overflow, most-negative / -1: lo_out = most-negative value (wraps), hi_out=0. No overflow flag.
- Arithmetic is modulo 2^WIDTH per output half. There is no saturation.
- busy is registered: high from cycle 1 through the DONE cycle inclusive.

Test Plan:
- Unsigned mult, WIDTH=32: a=0xFFFFFFFF, b=0xFFFFFFFF, is_signed=0 -> cycle 34: done=1, hi=0xFFFFFFFE, lo=0x00000001; busy=1 cycles 1-34, then 0.
- Signed mult: a=0xFFFFFFFD (-3), b=7, is_signed=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - Same operands with SIGNED_EN=0 -> hi=0x00000006, lo=0xFFFFFFEB.
- Divide:
  - Signed: a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Unsigned: a=100, b=7 -> lo=14, hi=2.
  - Signed overflow: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide-by-zero: prior result hi=2, lo=14; DivCtrl with a=5, b=0 -> cycle 1: done=1, DivZero=1; hi=2, lo=14 unchanged; next cycle busy=0, DivZero=0.
- Arbitration: MultCtrl=DivCtrl=1 with a=3, b=4 -> multiply, lo=12, hi=0. DivCtrl pulse in cycle 10 while busy -> ignored; exactly one done pulse at cycle 34.
- Reset mid-op: reset=0 asynchronously in cycle 10 of a multiply -> same cycle hi=lo=0, busy=0; no done after release. New MultCtrl a=2, b=5 -> lo=10, done 34 cycles later.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add MULT and restoring DIV over WIDTH cycles,
// signed or unsigned, with one-cycle done pulse and divide-by-zero flag.
module mult_div_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MultCtrl,
  input  logic             DivCtrl,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             DivZero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   op_div_q, op_div_d;
  logic                   neg_res_q, neg_res_d;
  logic                   neg_dvd_q, neg_dvd_d;
  logic                   dz_q, dz_d;
  // MULT: {product hi, multiplier/product lo}; DIV: low half holds dividend/quotient.
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       opb_q, opb_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;

  logic                   sgn_mode;
  logic                   a_neg, b_neg;
  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [WIDTH-1:0]       addend;
  logic [WIDTH:0]         sum;
  logic [WIDTH:0]         shifted;
  logic [WIDTH+1:0]       diff;
  logic [2*WIDTH-1:0]     prod_fix;

  always_comb begin
    sgn_mode = SIGNED_EN && is_signed;
    a_neg    = sgn_mode && a_in[WIDTH-1];
    b_neg    = sgn_mode && b_in[WIDTH-1];
    a_mag    = a_neg ? -a_in : a_in;
    b_mag    = b_neg ? -b_in : b_in;

    addend   = acc_q[0] ? opb_q : '0;
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    shifted  = {rem_q, acc_q[WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, opb_q};

    prod_fix = neg_res_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_div_d  = op_div_q;
    neg_res_d = neg_res_q;
    neg_dvd_d = neg_dvd_q;
    dz_d      = dz_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      StIdle: begin
        if (MultCtrl) begin
          op_div_d  = 1'b0;
          neg_res_d = a_neg ^ b_neg;
          neg_dvd_d = 1'b0;
          dz_d      = 1'b0;
          acc_d     = {{WIDTH{1'b0}}, b_mag};
          rem_d     = '0;
          opb_d     = a_mag;
          cnt_d     = CntW'(WIDTH - 1);
          state_d   = StRun;
        end else if (DivCtrl) begin
          op_div_d  = 1'b1;
          neg_res_d = a_neg ^ b_neg;
          neg_dvd_d = a_neg;
          acc_d     = {{WIDTH{1'b0}}, a_mag};
          rem_d     = '0;
          opb_d     = b_mag;
          cnt_d     = CntW'(WIDTH - 1);
          dz_d      = (b_in == '0);
          state_d   = (b_in == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (op_div_q) begin
          // Restore (keep shifted value) when the trial subtraction goes negative.
          if (!diff[WIDTH+1]) begin
            rem_d = diff[WIDTH-1:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (op_div_q) begin
          lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_dvd_q ? -rem_q : rem_q;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = StDone;
      end
      StDone: begin
        dz_d    = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_dvd_q <= 1'b0;
      dz_q      <= 1'b0;
      acc_q     <= '0;
      rem_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_div_q  <= op_div_d;
      neg_res_q <= neg_res_d;
      neg_dvd_q <= neg_dvd_d;
      dz_q      <= dz_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi_out  = hi_q;
  assign lo_out  = lo_q;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign DivZero = (state_q == StDone) && dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, signed/unsigned MULT/DIV, divide-by-zero,
// arbitration, ignored starts and asynchronous reset mid-operation.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         mult, div, sgn, mult2;
  logic [W-1:0] a, b;
  logic [W-1:0] hi, lo, hi2, lo2;
  logic         busy, done, dz, busy2, done2, dz2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .MultCtrl(mult), .DivCtrl(div), .is_signed(sgn),
    .a_in(a), .b_in(b), .hi_out(hi), .lo_out(lo), .busy(busy), .done(done), .DivZero(dz)
  );

  mult_div_unit #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut_nosgn (
    .clk(clk), .reset(reset), .MultCtrl(mult2), .DivCtrl(1'b0), .is_signed(sgn),
    .a_in(a), .b_in(b), .hi_out(hi2), .lo_out(lo2), .busy(busy2), .done(done2), .DivZero(dz2)
  );

  // Drive a one-cycle start; returns at the negedge inside cycle 1.
  task automatic launch(input logic m, input logic d, input logic s,
                        input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    mult = m; div = d; sgn = s; a = av; b = bv;
    @(negedge clk);
    mult = 1'b0; div = 1'b0;
  endtask

  // Observe 40 cycles from cycle 1; optionally pulse DivCtrl during cycle `inject`.
  task automatic wait_done(input int inject, output int dcyc, output int ndone,
                           output bit busy_ok, output bit busy_after, output bit dz_seen);
    dcyc = 0; ndone = 0; busy_ok = 1'b1; busy_after = 1'b1; dz_seen = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done) begin
        if (ndone == 0) dcyc = cyc;
        ndone++;
        if (dz) dz_seen = 1'b1;
      end
      if (dcyc == 0 && !busy) busy_ok = 1'b0;
      if (dcyc != 0 && cyc == dcyc + 1) busy_after = busy;
      if (cyc == inject) div = 1'b1;
      @(negedge clk);
      div = 1'b0;
    end
  endtask

  task automatic test_reset();
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL rst_hi: got %h want 0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL rst_lo: got %h want 0", lo); end
    total++; if ({busy, done, dz} !== 3'b000) begin
      bad++; $display("FAIL rst_flags: got %b want 000", {busy, done, dz});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mult_unsigned();
    int dc, nd; bit bo, ba, dzs;
    launch(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, dc, nd, bo, ba, dzs);
    total++; if (dc !== 34) begin bad++; $display("FAIL mu_latency: got %0d want 34", dc); end
    total++; if (nd !== 1) begin bad++; $display("FAIL mu_ndone: got %0d want 1", nd); end
    total++; if (bo !== 1'b1) begin bad++; $display("FAIL mu_busy: got %b want 1", bo); end
    total++; if (ba !== 1'b0) begin bad++; $display("FAIL mu_busy_after: got %b want 0", ba); end
    total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mu_hi: got %h want fffffffe", hi); end
    total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL mu_lo: got %h want 00000001", lo); end
  endtask

  task automatic test_mult_signed();
    int dc, nd; bit bo, ba, dzs;
    launch(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7);
    wait_done(0, dc, nd, bo, ba, dzs);
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ms_hi: got %h want ffffffff", hi); end
    total++; if (lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL ms_lo: got %h want ffffffeb", lo); end
    total++; if (dc !== 34) begin bad++; $display("FAIL ms_latency: got %0d want 34", dc); end
  endtask

  task automatic test_mult_signed_disabled();
    int dc;
    dc = 0;
    @(negedge clk);
    mult2 = 1'b1; sgn = 1'b1; a = 32'hFFFF_FFFD; b = 32'd7;
    @(negedge clk);
    mult2 = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done2 && dc == 0) dc = cyc;
      @(negedge clk);
    end
    total++; if (dc !== 34) begin bad++; $display("FAIL sd_latency: got %0d want 34", dc); end
    total++; if (hi2 !== 32'h0000_0006) begin bad++; $display("FAIL sd_hi: got %h want 00000006", hi2); end
    total++; if (lo2 !== 32'hFFFF_FFEB) begin bad++; $display("FAIL sd_lo: got %h want ffffffeb", lo2); end
  endtask

  task automatic test_div();
    int dc, nd; bit bo, ba, dzs;
    launch(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, dc, nd, bo, ba, dzs);
    total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL ds_lo: got %h want fffffffd", lo); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ds_hi: got %h want ffffffff", hi); end
    total++; if (dc !== 34) begin bad++; $display("FAIL ds_latency: got %0d want 34", dc); end
    total++; if (dzs !== 1'b0) begin bad++; $display("FAIL ds_divzero: got %b want 0", dzs); end

    launch(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, dc, nd, bo, ba, dzs);
    total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL dov_lo: got %h want 80000000", lo); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL dov_hi: got %h want 0", hi); end

    launch(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
    wait_done(0, dc, nd, bo, ba, dzs);
    total++; if (lo !== 32'd14) begin bad++; $display("FAIL du_lo: got %0d want 14", lo); end
    total++; if (hi !== 32'd2) begin bad++; $display("FAIL du_hi: got %0d want 2", hi); end
  endtask

  task automatic test_div_zero();
    launch(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
    total++; if ({done, dz} !== 2'b11) begin
      bad++; $display("FAIL dz_pulse: got %b want 11", {done, dz});
    end
    total++; if (hi !== 32'd2) begin bad++; $display("FAIL dz_hi: got %0d want 2", hi); end
    total++; if (lo !== 32'd14) begin bad++; $display("FAIL dz_lo: got %0d want 14", lo); end
    @(negedge clk);
    total++; if ({busy, done, dz} !== 3'b000) begin
      bad++; $display("FAIL dz_after: got %b want 000", {busy, done, dz});
    end
  endtask

  task automatic test_arbitration();
    int dc, nd; bit bo, ba, dzs;
    launch(1'b1, 1'b1, 1'b0, 32'd3, 32'd4);
    wait_done(10, dc, nd, bo, ba, dzs);
    total++; if (lo !== 32'd12) begin bad++; $display("FAIL arb_lo: got %0d want 12", lo); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL arb_hi: got %0d want 0", hi); end
    total++; if (dc !== 34) begin bad++; $display("FAIL arb_latency: got %0d want 34", dc); end
    total++; if (nd !== 1) begin bad++; $display("FAIL arb_ndone: got %0d want 1", nd); end
  endtask

  task automatic test_reset_mid_op();
    int dc, nd; bit bo, ba, dzs;
    launch(1'b1, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF);
    repeat (9) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL rm_lo: got %0d want 0", lo); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL rm_hi: got %0d want 0", hi); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done) nd++;
      @(negedge clk);
    end
    total++; if (nd !== 0) begin bad++; $display("FAIL rm_no_done: got %0d want 0", nd); end
    launch(1'b1, 1'b0, 1'b0, 32'd2, 32'd5);
    wait_done(0, dc, nd, bo, ba, dzs);
    total++; if (lo !== 32'd10) begin bad++; $display("FAIL rm_new_lo: got %0d want 10", lo); end
    total++; if (dc !== 34) begin bad++; $display("FAIL rm_new_latency: got %0d want 34", dc); end
  endtask

  initial begin
    mult = 1'b0; div = 1'b0; mult2 = 1'b0; sgn = 1'b0; a = '0; b = '0;
    #2;
    test_reset();
    test_mult_unsigned();
    test_mult_signed();
    test_mult_signed_disabled();
    test_div();
    test_div_zero();
    test_arbitration();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
